axi4_rd_burst_mst: RTL and testbench



---
 rtl/axi4_rd_burst_mst.sv | 269 ++++++++++++++++++++++++++
 tb/tb_axi4_rd_burst_mst.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_burst_mst.sv
// -----------------------------------------------------------------------------
// axi4_rd_burst_mst
//
// AXI4 read-burst initiator. Accepts one burst command, checks it for AXI4
// legality, issues a single AR transaction and forwards every R beat on a
// registered output stream, tagged with the byte address the beat belongs to
// (FIXED / INCR / WRAP stepping). A one-cycle done pulse closes each burst,
// with err reporting SLVERR/DECERR on any beat or an illegal command.
//
// Optional feature macro: AXI4_RD_MST_CHK_EN
//   defined   : RLAST position and RID are also checked and folded into err.
//   undefined : only RRESP[1] contributes to err; RLAST/RID are ignored.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cmd_*                      command handshake and burst descriptor
//   ar*                        AXI4 read-address channel (master side)
//   r*                         AXI4 read-data channel (master side)
//   dat_*                      registered beat output stream
//   done_o, err_o              end-of-burst pulse and its error status
// -----------------------------------------------------------------------------
module axi4_rd_burst_mst #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [3:0]            cmd_len_i,
   input  logic [2:0]            cmd_size_i,
   input  logic [1:0]            cmd_burst_i,
   input  logic [ID_WIDTH-1:0]   cmd_id_i,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   output logic [ADDR_WIDTH-1:0] araddr_o,
   output logic [7:0]            arlen_o,
   output logic [2:0]            arsize_o,
   output logic [1:0]            arburst_o,
   output logic [ID_WIDTH-1:0]   arid_o,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rlast_i,
   input  logic [ID_WIDTH-1:0]   rid_i,
   output logic                  dat_valid_o,
   input  logic                  dat_ready_i,
   output logic [DATA_WIDTH-1:0] dat_data_o,
   output logic [ADDR_WIDTH-1:0] dat_addr_o,
   output logic [1:0]            dat_resp_o,
   output logic                  dat_last_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int                  MAX_SIZE = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_DATA, ST_DONE} state_t;

   state_t                  state_reg;
   logic                    cmd_ready_reg;
   logic [3:0]              len_reg;
   logic [2:0]              size_reg;
   logic [1:0]              burst_reg;
   logic [ID_WIDTH-1:0]     id_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;      // address of the next R beat
   logic [3:0]              cnt_reg;       // index of the next R beat
   logic                    rcvd_all_reg;  // last R beat already taken
   logic                    err_flag_reg;
   logic                    arvalid_reg;
   logic [ADDR_WIDTH-1:0]   araddr_reg;
   logic [7:0]              arlen_reg;
   logic [2:0]              arsize_reg;
   logic [1:0]              arburst_reg;
   logic [ID_WIDTH-1:0]     arid_reg;
   logic                    dat_valid_reg;
   logic [DATA_WIDTH-1:0]   dat_data_reg;
   logic [ADDR_WIDTH-1:0]   dat_addr_reg;
   logic [1:0]              dat_resp_reg;
   logic                    dat_last_reg;
   logic                    done_reg;
   logic                    err_out_reg;

   // ---------------------------------------------------------------------------
   // Command legality
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] cmd_s;
   logic [ADDR_WIDTH-1:0] cmd_last_addr;
   logic                  cmd_wrap_len_ok;
   logic                  cmd_illegal;

   always_comb begin
      cmd_s           = ONE << cmd_size_i;
      // address of the final INCR beat: the start is aligned down first
      cmd_last_addr   = (cmd_addr_i & ~(cmd_s - ONE))
                        + (ADDR_WIDTH'(cmd_len_i) << cmd_size_i);
      cmd_wrap_len_ok = (cmd_len_i == 4'd1) || (cmd_len_i == 4'd3) ||
                        (cmd_len_i == 4'd7) || (cmd_len_i == 4'd15);
      cmd_illegal     = 1'b0;
      if (cmd_burst_i == 2'd3)
         cmd_illegal = 1'b1;
      if (cmd_size_i > 3'(MAX_SIZE))
         cmd_illegal = 1'b1;
      if ((cmd_burst_i == 2'd2) &&
          (!cmd_wrap_len_ok || ((cmd_addr_i & (cmd_s - ONE)) != '0)))
         cmd_illegal = 1'b1;
      if ((cmd_burst_i == 2'd1) &&
          (cmd_last_addr[ADDR_WIDTH-1:12] != cmd_addr_i[ADDR_WIDTH-1:12]))
         cmd_illegal = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Beat address stepping
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] beat_s;
   logic [ADDR_WIDTH-1:0] beat_b;
   logic [ADDR_WIDTH-1:0] next_addr;

   always_comb begin
      beat_s = ONE << size_reg;
      beat_b = (ADDR_WIDTH'(len_reg) + ONE) << size_reg;
      case (burst_reg)
         2'd1:    next_addr = (addr_reg & ~(beat_s - ONE)) + beat_s;
         2'd2:    next_addr = (addr_reg & ~(beat_b - ONE)) |
                              ((addr_reg + beat_s) & (beat_b - ONE));
         default: next_addr = addr_reg;
      endcase
   end

   // ---------------------------------------------------------------------------
   // R acceptance and per-beat error
   // ---------------------------------------------------------------------------
   logic beat_last;
   logic beat_err;
   logic r_hs;

   assign beat_last = (cnt_reg == len_reg);
   // Depends only on registered state and dat_ready_i, never on R inputs.
   assign rready_o  = (state_reg == ST_DATA) && !rcvd_all_reg &&
                      (!dat_valid_reg || dat_ready_i);
   assign r_hs      = rvalid_i && rready_o;

`ifdef AXI4_RD_MST_CHK_EN
   assign beat_err = rresp_i[1] | (rlast_i != beat_last) | (rid_i != id_reg);
`else
   logic unused_chk;
   assign beat_err   = rresp_i[1];
   assign unused_chk = ^{rlast_i, rid_i};
`endif

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         cmd_ready_reg <= 1'b1;
         len_reg       <= '0;
         size_reg      <= '0;
         burst_reg     <= '0;
         id_reg        <= '0;
         addr_reg      <= '0;
         cnt_reg       <= '0;
         rcvd_all_reg  <= 1'b0;
         err_flag_reg  <= 1'b0;
         arvalid_reg   <= 1'b0;
         araddr_reg    <= '0;
         arlen_reg     <= '0;
         arsize_reg    <= '0;
         arburst_reg   <= '0;
         arid_reg      <= '0;
         dat_valid_reg <= 1'b0;
         dat_data_reg  <= '0;
         dat_addr_reg  <= '0;
         dat_resp_reg  <= '0;
         dat_last_reg  <= 1'b0;
         done_reg      <= 1'b0;
         err_out_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  cmd_ready_reg <= 1'b0;
                  len_reg       <= cmd_len_i;
                  size_reg      <= cmd_size_i;
                  burst_reg     <= cmd_burst_i;
                  id_reg        <= cmd_id_i;
                  addr_reg      <= cmd_addr_i;
                  cnt_reg       <= '0;
                  rcvd_all_reg  <= 1'b0;
                  err_flag_reg  <= 1'b0;
                  araddr_reg    <= cmd_addr_i;
                  arlen_reg     <= {4'b0, cmd_len_i};
                  arsize_reg    <= cmd_size_i;
                  arburst_reg   <= cmd_burst_i;
                  arid_reg      <= cmd_id_i;
                  if (cmd_illegal) begin
                     // rejected without touching the bus
                     state_reg   <= ST_DONE;
                     done_reg    <= 1'b1;
                     err_out_reg <= 1'b1;
                  end else begin
                     state_reg   <= ST_AR;
                     arvalid_reg <= 1'b1;
                  end
               end
            end
            ST_AR: begin
               if (arready_i) begin
                  arvalid_reg <= 1'b0;
                  state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Downstream consume first; an R beat in the same cycle refills.
               if (dat_valid_reg && dat_ready_i) begin
                  dat_valid_reg <= 1'b0;
                  dat_last_reg  <= 1'b0;
                  if (dat_last_reg) begin
                     state_reg   <= ST_DONE;
                     done_reg    <= 1'b1;
                     err_out_reg <= err_flag_reg;
                  end
               end
               if (r_hs) begin
                  dat_valid_reg <= 1'b1;
                  dat_data_reg  <= rdata_i;
                  dat_resp_reg  <= rresp_i;
                  dat_addr_reg  <= addr_reg;
                  dat_last_reg  <= beat_last;
                  addr_reg      <= next_addr;
                  cnt_reg       <= cnt_reg + 4'd1;
                  err_flag_reg  <= err_flag_reg | beat_err;
                  if (beat_last)
                     rcvd_all_reg <= 1'b1;
               end
            end
            ST_DONE: begin
               done_reg      <= 1'b0;
               err_out_reg   <= 1'b0;
               err_flag_reg  <= 1'b0;
               cmd_ready_reg <= 1'b1;
               state_reg     <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_reg;
   assign arvalid_o   = arvalid_reg;
   assign araddr_o    = araddr_reg;
   assign arlen_o     = arlen_reg;
   assign arsize_o    = arsize_reg;
   assign arburst_o   = arburst_reg;
   assign arid_o      = arid_reg;
   assign dat_valid_o = dat_valid_reg;
   assign dat_data_o  = dat_data_reg;
   assign dat_addr_o  = dat_addr_reg;
   assign dat_resp_o  = dat_resp_reg;
   assign dat_last_o  = dat_last_reg;
   assign done_o      = done_reg;
   assign err_o       = err_out_reg;

endmodule

// File: tb/tb_axi4_rd_burst_mst.sv
// -----------------------------------------------------------------------------
// tb_axi4_rd_burst_mst
//
// Directed bench for axi4_rd_burst_mst. A driver plays command source, AXI
// slave and downstream sink cycle by cycle; a reference model computes the
// expected beats (address, data, resp, last) and the end-of-burst error from
// the AXI4 burst rules; a compare process checks the DUT against that model on
// every cycle where outputs carry meaning. Literal address lists pin the model.
// -----------------------------------------------------------------------------
module tb_axi4_rd_burst_mst;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [AW-1:0] cmd_addr_i;
   logic [3:0]    cmd_len_i;
   logic [2:0]    cmd_size_i;
   logic [1:0]    cmd_burst_i;
   logic [IW-1:0] cmd_id_i;
   logic          arvalid_o;
   logic          arready_i;
   logic [AW-1:0] araddr_o;
   logic [7:0]    arlen_o;
   logic [2:0]    arsize_o;
   logic [1:0]    arburst_o;
   logic [IW-1:0] arid_o;
   logic          rvalid_i;
   logic          rready_o;
   logic [DW-1:0] rdata_i;
   logic [1:0]    rresp_i;
   logic          rlast_i;
   logic [IW-1:0] rid_i;
   logic          dat_valid_o;
   logic          dat_ready_i;
   logic [DW-1:0] dat_data_o;
   logic [AW-1:0] dat_addr_o;
   logic [1:0]    dat_resp_o;
   logic          dat_last_o;
   logic          done_o;
   logic          err_o;

   always #5 clk = ~clk;

   axi4_rd_burst_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_size_i(cmd_size_i),
      .cmd_burst_i(cmd_burst_i), .cmd_id_i(cmd_id_i),
      .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
      .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o), .arid_o(arid_o),
      .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
      .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i),
      .dat_valid_o(dat_valid_o), .dat_ready_i(dat_ready_i), .dat_data_o(dat_data_o),
      .dat_addr_o(dat_addr_o), .dat_resp_o(dat_resp_o), .dat_last_o(dat_last_o),
      .done_o(done_o), .err_o(err_o)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   int            checks   = 0;
   int            failures = 0;
   int            cmd_n    = 0;
   beat_t         exp_q[$];
   logic [AW-1:0] got_q[$];
   bit            exp_err;
   logic [AW-1:0] exp_araddr;
   logic [3:0]    exp_len;
   logic [2:0]    exp_size;
   logic [1:0]    exp_burst;
   logic [IW-1:0] exp_id;
   logic [7:0]    got_arlen;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   // ---------------- reference model (AXI4 burst rules) ----------------
   function automatic bit model_legal(input longint addr, input int len,
                                      input int size, input int burst);
      longint s = longint'(1) << size;
      if (burst == 3) return 1'b0;
      if (size > 3) return 1'b0;               // 64-bit data bus
      if (burst == 2) begin
         if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
         if (addr % s != 0) return 1'b0;
      end
      if (burst == 1) begin
         if (((addr / s) * s + len * s) / 4096 != addr / 4096) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [AW-1:0] model_addr(input longint addr, input int len,
                                                input int size, input int burst,
                                                input int i);
      longint s = longint'(1) << size;
      longint b = (len + 1) * s;
      longint base;
      longint r;
      case (burst)
         1: r = (i == 0) ? addr : (addr / s) * s + i * s;
         2: begin
            base = (addr / b) * b;
            r    = base + ((addr - base + i * s) % b);
         end
         default: r = addr;
      endcase
      return r[AW-1:0];
   endfunction

   function automatic logic [DW-1:0] bdata(input int n, input int i);
      return {16'h5A5A, 16'(n), 16'hBEEF, 16'(i)};
   endfunction

   // ---------------- compare process ----------------
   bit            stalled = 1'b0;
   logic [DW-1:0] sv_data;
   logic [AW-1:0] sv_addr;
   logic [1:0]    sv_resp;
   logic          sv_last;

   always begin
      beat_t e;
      @(negedge clk);
      #2;
      if (rst_i) begin
         stalled = 1'b0;
      end else begin
         if (dat_valid_o && !dat_ready_i)
            chk(!rready_o, "rready_stall", 64'(rready_o), 64'd0);
         if (stalled)
            chk(dat_valid_o && dat_data_o == sv_data && dat_addr_o == sv_addr &&
                dat_resp_o == sv_resp && dat_last_o == sv_last,
                "hold_stable", dat_addr_o, sv_addr);
         if (dat_valid_o && dat_ready_i) begin
            got_q.push_back(dat_addr_o);
            if (exp_q.size() == 0) begin
               chk(1'b0, "beat_unexpected", dat_addr_o, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk(dat_addr_o == e.addr, "beat_addr", dat_addr_o, e.addr);
               chk(dat_data_o == e.data, "beat_data", dat_data_o, e.data);
               chk(dat_resp_o == e.resp, "beat_resp", 64'(dat_resp_o), 64'(e.resp));
               chk(dat_last_o == e.last, "beat_last", 64'(dat_last_o), 64'(e.last));
            end
         end
         if (arvalid_o && arready_i) begin
            got_arlen = arlen_o;
            chk(araddr_o == exp_araddr, "araddr", araddr_o, exp_araddr);
            chk(arlen_o == {4'b0, exp_len} && arsize_o == exp_size &&
                arburst_o == exp_burst && arid_o == exp_id, "ar_payload",
                {arid_o, arburst_o, arsize_o, arlen_o},
                {exp_id, exp_burst, exp_size, 4'b0, exp_len});
         end
         if (done_o) begin
            chk(err_o == exp_err, "err_at_done", 64'(err_o), 64'(exp_err));
            chk(exp_q.size() == 0, "beats_left", 64'(exp_q.size()), 64'd0);
         end
         stalled = dat_valid_o && !dat_ready_i;
         sv_data = dat_data_o;
         sv_addr = dat_addr_o;
         sv_resp = dat_resp_o;
         sv_last = dat_last_o;
      end
   end

   // ---------------- driver ----------------
   task automatic run_burst(input logic [AW-1:0] addr, input int len, input int size,
                            input int burst, input logic [IW-1:0] id,
                            input int slverr, input int badlast,
                            input int stall_at, input int stall_n,
                            input int ar_delay, input int rst_at);
      bit legal;
      bit hs;
      bit done_seen;
      bit prev_final;
      bit r_hs;
      int beat;
      int cyc;
      beat_t e;
      cmd_n++;
      legal = model_legal(longint'(addr), len, size, burst);
      exp_q.delete();
      got_q.delete();
      exp_err = !legal;
      if (legal) begin
         for (int i = 0; i <= len; i++) begin
            e.addr = model_addr(longint'(addr), len, size, burst, i);
            e.data = bdata(cmd_n, i);
            e.resp = (i == slverr) ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_q.push_back(e);
         end
         if (slverr >= 0 && slverr <= len) exp_err = 1'b1;
`ifdef AXI4_RD_MST_CHK_EN
         if (badlast >= 0 && badlast != len) exp_err = 1'b1;
`endif
      end
      exp_araddr = addr;
      exp_len    = 4'(len);
      exp_size   = 3'(size);
      exp_burst  = 2'(burst);
      exp_id     = id;

      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_len_i   = 4'(len);
      cmd_size_i  = 3'(size);
      cmd_burst_i = 2'(burst);
      cmd_id_i    = id;
      #1;
      chk(cmd_ready_o, "cmd_ready", 64'(cmd_ready_o), 64'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      #1;
      if (!legal) begin
         chk(done_o && err_o && !arvalid_o, "illegal_done",
             {done_o, err_o, arvalid_o}, 3'b110);
         @(negedge clk);
         #1;
         chk(!done_o && !arvalid_o && cmd_ready_o, "illegal_pulse",
             {done_o, arvalid_o, cmd_ready_o}, 3'b001);
         $display("cmd %0d addr=%h len=%0d size=%0d burst=%0d rejected", cmd_n,
                  addr, len, size, burst);
         return;
      end
      chk(arvalid_o, "ar_latency", 64'(arvalid_o), 64'd1);

      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) begin
         if (k > 0) @(negedge clk);
         arready_i = (k >= ar_delay);
         #1;
         hs = arvalid_o && arready_i;
         @(posedge clk);
      end
      if (!hs) chk(1'b0, "ar_timeout", 64'(arvalid_o), 64'd1);

      beat       = 0;
      cyc        = 0;
      done_seen  = 1'b0;
      prev_final = 1'b0;
      while (!done_seen && cyc < 300) begin
         @(negedge clk);
         arready_i = 1'b0;
         if (rst_at >= 0 && cyc == rst_at) begin
            rst_i = 1'b1;
            #1;
            chk(cmd_ready_o && !arvalid_o && !rready_o && !dat_valid_o &&
                !dat_last_o && !done_o && !err_o && dat_addr_o == '0,
                "rst_mid_burst", {cmd_ready_o, arvalid_o, rready_o, dat_valid_o,
                done_o, err_o}, 6'b100000);
            exp_q.delete();
            rvalid_i = 1'b0;
            @(negedge clk);
            rst_i = 1'b0;
            $display("cmd %0d addr=%h aborted by reset after %0d beats", cmd_n,
                     addr, got_q.size());
            return;
         end
         rvalid_i    = (beat <= len);
         rdata_i     = bdata(cmd_n, beat);
         rresp_i     = (beat == slverr) ? 2'b10 : 2'b00;
         rlast_i     = (badlast >= 0) ? (beat == badlast) : (beat == len);
         rid_i       = id;
         dat_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_n);
         #1;
         if (done_o || prev_final) begin
            chk(done_o && prev_final, "done_latency", 64'(done_o), 64'(prev_final));
            done_seen = 1'b1;
         end
         prev_final = dat_valid_o && dat_ready_i && dat_last_o;
         r_hs       = rvalid_i && rready_o;
         @(posedge clk);
         if (r_hs) beat++;
         cyc++;
      end
      rvalid_i    = 1'b0;
      dat_ready_i = 1'b1;
      if (!done_seen) chk(1'b0, "done_timeout", 64'(cyc), 64'd300);
      chk(got_q.size() == len + 1, "beat_count", 64'(got_q.size()), 64'(len + 1));
      @(negedge clk);
      #1;
      chk(!done_o && cmd_ready_o, "done_pulse", {done_o, cmd_ready_o}, 2'b01);
      $display("cmd %0d addr=%h len=%0d size=%0d burst=%0d beats=%0d exp_err=%0d",
               cmd_n, addr, len, size, burst, got_q.size(), exp_err);
   endtask

   task automatic check_addrs(input string nm, input int n, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [AW-1:0] a3);
      logic [AW-1:0] req[4];
      logic [AW-1:0] act;
      req = '{a0, a1, a2, a3};
      for (int i = 0; i < n; i++) begin
         act = (i < got_q.size()) ? got_q[i] : 'x;
         chk(i < got_q.size() && act == req[i], nm, act, req[i]);
      end
   endtask

   initial begin
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_len_i   = '0;
      cmd_size_i  = '0;
      cmd_burst_i = '0;
      cmd_id_i    = '0;
      arready_i   = 1'b0;
      rvalid_i    = 1'b0;
      rdata_i     = '0;
      rresp_i     = '0;
      rlast_i     = 1'b0;
      rid_i       = '0;
      dat_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk(cmd_ready_o && !arvalid_o && !rready_o && !dat_valid_o && !done_o &&
          !err_o && dat_addr_o == '0 && araddr_o == '0 && arlen_o == '0,
          "reset_values", {cmd_ready_o, arvalid_o, rready_o, dat_valid_o, done_o,
          err_o}, 6'b100000);
      rst_i = 1'b0;

      // addr len size burst id slverr badlast stall_at stall_n ar_delay rst_at
      run_burst(32'h1004, 3, 2, 1, 4'h3, -1, -1, -1, 0, 0, -1);
      check_addrs("incr_addrs", 4, 32'h1004, 32'h1008, 32'h100C, 32'h1010);
      chk(got_arlen == 8'd3, "arlen_lit", 64'(got_arlen), 64'd3);

      run_burst(32'h1038, 3, 2, 2, 4'h5, -1, -1, -1, 0, 3, -1);
      check_addrs("wrap_addrs", 4, 32'h1038, 32'h103C, 32'h1030, 32'h1034);

      run_burst(32'h0020, 2, 2, 0, 4'h1, -1, -1, -1, 0, 0, -1);
      check_addrs("fixed_addrs", 3, 32'h20, 32'h20, 32'h20, 32'h0);

      run_burst(32'h1003, 1, 3, 1, 4'h2, -1, -1, -1, 0, 1, -1);
      check_addrs("incr_unaligned", 2, 32'h1003, 32'h1008, 32'h0, 32'h0);

      run_burst(32'h1000, 2, 2, 2, 4'h0, -1, -1, -1, 0, 0, -1);   // WRAP len 2
      run_burst(32'h0FFC, 1, 2, 1, 4'h0, -1, -1, -1, 0, 0, -1);   // 4 KB crossing
      run_burst(32'h0100, 1, 2, 3, 4'h0, -1, -1, -1, 0, 0, -1);   // reserved burst
      run_burst(32'h0100, 1, 4, 1, 4'h0, -1, -1, -1, 0, 0, -1);   // size too big
      run_burst(32'h1034, 3, 2, 2, 4'h0, -1, -1, -1, 0, 0, -1);   // wrap unaligned... legal
      check_addrs("wrap_mid", 4, 32'h1034, 32'h1038, 32'h103C, 32'h1030);

      run_burst(32'h2000, 7, 3, 1, 4'h7, -1, -1, 3, 5, 0, -1);    // downstream stall
      check_addrs("stall_addrs", 4, 32'h2000, 32'h2008, 32'h2010, 32'h2018);

      run_burst(32'h3000, 3, 2, 1, 4'h4, 1, -1, -1, 0, 0, -1);    // SLVERR beat 2
      run_burst(32'h3100, 3, 2, 1, 4'h4, -1, 2, -1, 0, 0, -1);    // RLAST on beat 3
      run_burst(32'h0FF0, 3, 2, 1, 4'h6, -1, -1, 1, 2, 0, -1);    // ends at page edge
      check_addrs("page_edge", 4, 32'h0FF0, 32'h0FF4, 32'h0FF8, 32'h0FFC);

      run_burst(32'h4000, 7, 2, 1, 4'h9, -1, -1, 2, 4, 0, 4);     // reset mid-burst
      run_burst(32'h4000, 1, 1, 1, 4'hA, -1, -1, -1, 0, 0, -1);   // recovery
      check_addrs("after_reset", 2, 32'h4000, 32'h4002, 32'h0, 32'h0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
